// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: redirect input, instruction-memory read port and
// the decoded-stage output handshake. The master side is the fetch unit.
interface instr_fetch_if;
  logic        clk_enable;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_address;
  logic        imem_read;
  logic        imem_waitrequest;
  logic [31:0] imem_readdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        halted;

  modport master (
    input  clk_enable, redirect_valid, redirect_target,
    input  imem_waitrequest, imem_readdata, instr_ready,
    output imem_address, imem_read,
    output instr_valid, instruction, pc, pc4, halted
  );

  modport slave (
    output clk_enable, redirect_valid, redirect_target,
    output imem_waitrequest, imem_readdata, instr_ready,
    input  imem_address, imem_read,
    input  instr_valid, instruction, pc, pc4, halted
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit with one branch delay slot. Reads one word per
// cycle from instruction memory into a single output register, follows
// taken branches after their delay slot, and halts sticky on reaching
// address 0.
module instr_fetch (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.master bus
);

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic [31:0] fetch_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        pending;
  logic [31:0] pending_target;
  logic        halt_flag;

  logic        handshake;
  logic        read_req;
  logic        read_done;
  logic        read_stall;
  logic        redirect_take;
  logic        in_sequence;
  logic [31:0] target_word;

  // Branch targets are word addresses; the byte-offset bits are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  assign handshake   = out_valid & bus.instr_ready;
  // A new read is only started when its result has somewhere to go: the
  // output register is empty or is being drained in this same cycle.
  assign read_req    = ~reset & bus.clk_enable & ~halt_flag &
                       (fetch_pc != 32'd0) & (~out_valid | handshake);
  assign read_done   = read_req & ~bus.imem_waitrequest;
  assign read_stall  = read_req & bus.imem_waitrequest;
  // A redirect belongs to the instruction being handed off; while a delay
  // slot is still outstanding a further redirect is dropped.
  assign redirect_take = bus.clk_enable & handshake & bus.redirect_valid & ~pending;
  // True when the word after the branch (its delay slot) is still the one
  // to be fetched next.
  assign in_sequence = (fetch_pc == out_pc + 32'd4);
  assign target_word = align_word(bus.redirect_target);

  // Fetch address, output register, delay-slot tracking and halt state.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc       <= RESET_PC;
      out_valid      <= 1'b0;
      out_instr      <= 32'd0;
      out_pc         <= 32'd0;
      pending        <= 1'b0;
      pending_target <= 32'd0;
      halt_flag      <= 1'b0;
    end else if (bus.clk_enable) begin
      if (read_done) begin
        out_valid <= 1'b1;
        out_instr <= bus.imem_readdata;
        out_pc    <= fetch_pc;
      end else if (handshake) begin
        out_valid <= 1'b0;
      end

      if (redirect_take) begin
        if (read_done) begin
          // The delay slot (or the already-chosen successor) is landing now,
          // so the very next fetch can go straight to the target.
          fetch_pc <= target_word;
          pending  <= 1'b0;
        end else if (in_sequence || read_stall) begin
          // Let the outstanding read finish at its held address first.
          pending        <= 1'b1;
          pending_target <= target_word;
        end else begin
          fetch_pc <= target_word;
        end
      end else if (read_done) begin
        if (pending) begin
          fetch_pc <= pending_target;
          pending  <= 1'b0;
        end else begin
          fetch_pc <= fetch_pc + 32'd4;
        end
      end

      if (!out_valid && (fetch_pc == 32'd0)) begin
        halt_flag <= 1'b1;
      end
    end
  end

  assign bus.imem_address = fetch_pc;
  assign bus.imem_read    = read_req;
  assign bus.instr_valid  = out_valid;
  assign bus.instruction  = out_instr;
  assign bus.pc           = out_pc;
  assign bus.pc4          = out_pc + 32'd4;
  assign bus.halted       = halt_flag;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; both ports SHALL be named exactly as below.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 clk_enable  in  1  low: all state frozen, imem_read forced 0.
REQ-005 redirect_valid  in  1  taken branch/jump from pc_update, qualified by output handshake.
REQ-006 redirect_target  in  32  byte address of taken branch/jump target.
REQ-007 imem_address  out  32  instruction memory word address (byte address, bits[1:0]=00).
REQ-008 imem_read  out  1  read request to instruction memory.
REQ-009 imem_waitrequest  in  1  high: read not accepted this cycle; hold address and read.
REQ-010 imem_readdata  in  32  valid in any cycle with imem_read=1 and imem_waitrequest=0.
REQ-011 instr_valid  out  1  instruction/pc/pc4 outputs hold a fetched instruction.
REQ-012 instr_ready  in  1  downstream accepts output; handshake = instr_valid & instr_ready.
REQ-013 instruction  out  32  fetched instruction word.
REQ-014 pc  out  32  byte address of instruction.
REQ-015 pc4  out  32  pc+4, modulo 2^32.
REQ-016 halted  out  1  sticky; fetch reached address 0x00000000.

Function
REQ-017 State SHALL be: fetch_pc (32), output register (valid, instruction, pc), pending (1), pending_target (32), halted (1).
REQ-018 imem_read SHALL be 1 when clk_enable=1, halted=0, fetch_pc!=0, and output register is empty or being handshaken this cycle; imem_address SHALL equal fetch_pc.
REQ-019 A read completes in a cycle with imem_read=1 and imem_waitrequest=0; the next cycle instr_valid=1, instruction=captured imem_readdata, pc=fetched address.
REQ-020 Completed read with no handshake pending SHALL give a throughput of one instruction per cycle with zero wait states.
REQ-021 While imem_waitrequest=1, imem_address SHALL stay constant and imem_read SHALL stay 1.
REQ-022 Output register SHALL hold its value while instr_valid=1 and instr_ready=0.
REQ-023 On read completion with pending=0, fetch_pc SHALL become fetch_pc+4.
REQ-024 On read completion with pending=1 (delay slot fetched), fetch_pc SHALL become pending_target and pending SHALL clear.
REQ-025 redirect_valid SHALL be honoured only in a handshake cycle with pending=0; it sets pending=1, pending_target=redirect_target; otherwise it is ignored.
REQ-026 If redirect is honoured and the delay-slot read completes in the same cycle, fetch_pc SHALL become redirect_target directly and pending SHALL stay 0.
REQ-027 If the delay slot is already fetched when redirect is honoured (fetch_pc != pc+4 of branch), the block SHALL set fetch_pc to redirect_target directly.
REQ-028 When fetch_pc=0x00000000 and the output register is empty, halted SHALL assert next cycle and remain 1 until reset; no read is issued to address 0.
REQ-029 Address arithmetic SHALL wrap modulo 2^32; target bits[1:0] SHALL be ignored (forced 00).

Reset
REQ-030 On reset: fetch_pc=0xBFC00000, instr_valid=0, instruction=0, pc=0, pending=0, pending_target=0, halted=0, imem_read=0.
REQ-031 Reset SHALL override clk_enable and abandon any in-flight read; the first read of 0xBFC00000 is issued in the first cycle after reset deasserts.

Verification
REQ-032 Reset, waitrequest=0, ready=1 -> reads at 0xBFC00000, 0xBFC00004, 0xBFC00008 on consecutive cycles; instr_valid from cycle 2.
REQ-033 waitrequest high 3 cycles on 0xBFC00004 -> address held 3 cycles, instr_valid low after first instruction consumed, then resumes at 0xBFC00008.
REQ-034 Redirect to 0xBFC00100 on handshake of pc=0xBFC00000 -> delay slot pc=0xBFC00004 delivered, next pc=0xBFC00100.
REQ-035 Second redirect during delay-slot handshake (pending=1) -> ignored; sequence continues at first target.
REQ-036 Redirect to 0x00000000 -> delay slot delivered, then halted=1, imem_read stays 0 until reset.
REQ-037 instr_ready=0 for 4 cycles with valid output -> instruction/pc stable, at most one further read completes.
